seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 2..255), giving the consecutive identical samples required before a digit is captured.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port seg, input, 7 bits: active-low segment bus; bit0=a through bit6=g; 0 = lit.
REQ-005 SHALL have port an, input, 4 bits: active-low digit enables; bit3 = most significant digit.
REQ-006 SHALL have port value, output, 16 bits: last complete decoded frame, digit3 in [15:12] through digit0 in [3:0].
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse marking a value update.
REQ-008 SHALL have port err, output, 4 bits: per-digit flag for an unrecognised pattern in the last frame.

Function
REQ-009 SHALL decode seg to a nibble using this 16-entry table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-010 SHALL treat any other seg value as unrecognised, including blank 1111111: the nibble is 4'h0 and the digit error bit is 1.
REQ-011 SHALL treat a sample as a digit sample only when exactly one bit of an is 0; any other an value is idle.
REQ-012 SHALL clear the stability counter and the dwell-captured flag on an idle sample, or when seg or an differs from the previous sample.
REQ-013 SHALL increment the stability counter on each digit sample that matches the previous sample, and saturate it at STABLE_CYCLES-1.
REQ-014 SHALL capture on the edge at which the counter reaches STABLE_CYCLES-1 while the dwell-captured flag is 0; a capture writes the nibble and error bit into the shadow slot for the active digit, sets that digit's seen bit and sets the dwell-captured flag.
REQ-015 SHALL allow at most one capture per unchanged dwell, however long the dwell lasts.
REQ-016 SHALL, when a digit already marked seen is recaptured before the frame completes, overwrite its shadow slot and leave the seen bits unchanged.
REQ-017 SHALL complete a frame on the edge at which a capture makes seen equal to 4'b1111: on that same edge value and err load from the shadow (including the new capture), valid rises for exactly one cycle, and seen clears to 4'b0000.
REQ-018 SHALL hold value and err stable between frame completions.
REQ-019 SHALL make the capture latency, in the unsynchronised build, exactly STABLE_CYCLES cycles from the first sample of a new stable pattern to the capturing edge.

Reset
REQ-020 SHALL, while reset is high and independent of clk, force value=16'h0000, valid=0, err=4'b0000, seen=4'b0000, shadow=0, stability counter=0 and dwell-captured flag=0.
REQ-021 SHALL discard a partially collected frame on reset; after reset deassertion, all four digits must be captured again before valid asserts.

Configuration
REQ-022 SHALL, with macro SEG7_SYNC_EN defined, pass seg and an through a two-flop synchroniser that resets to all-ones (inactive); all latencies increase by 2 cycles.
REQ-023 SHALL, without SEG7_SYNC_EN, sample seg and an directly, with no added latency and no synchroniser flops.

Verification
REQ-024 SHALL cover a full frame (STABLE_CYCLES=4): an=0111/seg=1111001, an=1011/seg=0100100, an=1101/seg=0110000, an=1110/seg=0011001, each held 8 cycles -> value=16'h1234, err=0000, valid high exactly 1 cycle, on the 4th cycle of the last dwell.
REQ-025 SHALL cover a glitch: a digit pattern held 3 cycles then changed -> no capture and no valid.
REQ-026 SHALL cover an unrecognised pattern: a frame with digit2 seg=1010101 and the other digits 7,0,5 -> value=16'h7005, err=0100.
REQ-027 SHALL cover an illegal enable: an=1100 held 20 cycles, then a valid digit -> no capture during the 20 cycles; normal capture afterwards.
REQ-028 SHALL cover reset mid-frame: reset after 2 captures -> all outputs 0; valid only after four new captures.
REQ-029 SHALL cover a long dwell: digit0 held 100 cycles, then the other three digits -> exactly one capture of digit0 and one valid; repeat the full frame with SEG7_SYNC_EN defined -> valid 2 cycles later.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value by watching a multiplexed, active-low 7-segment bus.
// Define SEG7_SYNC_EN to pass seg/an through a two-flop synchroniser first.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  err
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_smp;
  logic [3:0] an_smp;

`ifdef SEG7_SYNC_EN
  logic [6:0] seg_s1_q, seg_s2_q;
  logic [3:0] an_s1_q, an_s2_q;

  // Synchroniser idles at all-ones so reset looks like a blank, unselected bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  assign seg_smp = seg_s2_q;
  assign an_smp  = an_s2_q;
`else
  assign seg_smp = seg;
  assign an_smp  = an;
`endif

  // Returns {err, nibble}; unrecognised patterns (including blank) decode as 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [6:0]  prev_seg_q, prev_seg_d;
  logic [3:0]  prev_an_q, prev_an_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dwell_q, dwell_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;
  logic        valid_q, valid_d;

  logic [3:0]  an_act;
  logic        is_digit;
  logic        same;
  logic        capture;
  logic [4:0]  dec;

  assign an_act   = ~an_smp;
  assign is_digit = (an_act != 4'b0000) && ((an_act & (an_act - 4'd1)) == 4'b0000);
  assign same     = (seg_smp == prev_seg_q) && (an_smp == prev_an_q);
  assign dec      = decode(seg_smp);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the block infers a latch.
    prev_seg_d   = seg_smp;
    prev_an_d    = an_smp;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    shadow_val_d = shadow_val_q;
    shadow_err_d = shadow_err_q;
    seen_d       = seen_q;
    value_d      = value_q;
    err_d        = err_q;
    valid_d      = 1'b0;
    capture      = 1'b0;

    if (!is_digit || !same) begin
      cnt_d   = 8'd0;
      dwell_d = 1'b0;
    end else begin
      if (cnt_q < CNT_LAST) cnt_d = cnt_q + 8'd1;
      capture = (cnt_d == CNT_LAST) && !dwell_q;
    end

    if (capture) begin
      dwell_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (an_act[i]) begin
          shadow_val_d[i*4 +: 4] = dec[3:0];
          shadow_err_d[i]        = dec[4];
        end
      end
      seen_d = seen_q | an_act;
      // The completing capture is forwarded straight into the published frame.
      if (seen_d == 4'b1111) begin
        value_d = shadow_val_d;
        err_d   = shadow_err_d;
        valid_d = 1'b1;
        seen_d  = 4'b0000;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next-state logic lives above.
  // NOTE: the shadow slots are reset as well, so a discarded frame can never leak old digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_seg_q   <= '1;
      prev_an_q    <= '1;
      cnt_q        <= '0;
      dwell_q      <= 1'b0;
      shadow_val_q <= '0;
      shadow_err_q <= '0;
      seen_q       <= '0;
      value_q      <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      prev_seg_q   <= prev_seg_d;
      prev_an_q    <= prev_an_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      shadow_val_q <= shadow_val_d;
      shadow_err_q <= shadow_err_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
    end
  end

  assign value = value_q;
  assign err   = err_q;
  assign valid = valid_q;

endmodule
